// File: rtl/seq_compare_nbit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_compare_nbit_pkg
//  Description : Shared constants for the multi-cycle magnitude comparator.
//                Holds the controller state encoding, the result-flag bit
//                positions (also used by the ALU decoder) and the
//                width/chunk split check.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_compare_nbit_pkg;

    // Controller state encoding
    localparam int         c_STATE_W  = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Result flag bit positions inside the packed {gt, eq, lt} vector
    localparam int c_FLAG_W  = 3;
    localparam int c_FLAG_LT = 0;
    localparam int c_FLAG_EQ = 1;
    localparam int c_FLAG_GT = 2;

    // An operand must split into a whole number of non-empty chunks
    function automatic bit isValidSplit(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage : seq_compare_nbit_pkg
`default_nettype wire

// File: rtl/seq_compare_nbit_chunk_compare.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_compare
//  Description : Combinational unsigned compare of one CHUNK-bit slice.
//                Produces less-than and equal; greater-than is implied.
//  Revision    : 1.0 - initial release
// ============================================================================
module chunk_compare #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             lt,
    output logic             eq
);

    // Plain unsigned magnitude compare; signedness is handled by the caller
    always_comb begin
        lt = (x < y);
        eq = (x == y);
    end

endmodule : chunk_compare
`default_nettype wire

// File: rtl/seq_compare_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_compare_nbit
//  Description : Multi-cycle magnitude comparator. Walks the captured
//                operands CHUNK bits per cycle starting at the MSB chunk and
//                reports exactly one of lt/eq/gt with a one-cycle done pulse.
//                Optional early exit at the first differing chunk.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_compare_nbit
    import seq_compare_nbit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             less_than,
    output logic             equal,
    output logic             greater_than
);

    localparam int c_NCHUNK = WIDTH / CHUNK;
    localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_IDX_W-1:0] c_MSB_IDX = c_IDX_W'(c_NCHUNK - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

    generate
        if (!isValidSplit(WIDTH, CHUNK)) begin : g_badSplit
            $error("seq_compare_nbit: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_stateNext;
    logic [c_IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_signed;
    logic                 r_diffSeen;
    logic [c_FLAG_W-1:0]  r_flags;

    logic                 w_isMsb;
    logic                 w_isLast;
    logic [CHUNK-1:0]     w_chunkA;
    logic [CHUNK-1:0]     w_chunkB;
    logic                 w_chunkLt;
    logic                 w_chunkEq;
    logic                 w_accept;

    // Operands are shifted left each RUN cycle, so the chunk under test is
    // always the top slice; r_idx only tracks how many chunks remain.
    always_comb begin
        w_isMsb  = (r_idx == c_MSB_IDX);
        w_isLast = (r_idx == '0);
        w_accept = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
        w_chunkA = r_a[WIDTH-1 -: CHUNK];
        w_chunkB = r_b[WIDTH-1 -: CHUNK];
        // Flipping both sign bits maps two's-complement order onto unsigned order
        if (r_signed && w_isMsb) begin
            w_chunkA[CHUNK-1] = ~w_chunkA[CHUNK-1];
            w_chunkB[CHUNK-1] = ~w_chunkB[CHUNK-1];
        end
    end

    chunk_compare #(
        .CHUNK (CHUNK)
    ) u_chunkCompare (
        .x  (w_chunkA),
        .y  (w_chunkB),
        .lt (w_chunkLt),
        .eq (w_chunkEq)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state: finish on first difference (early exit) or after the last chunk
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_stateNext = c_ST_RUN;
            end
            c_ST_RUN: begin
                if ((EARLY_EXIT && !w_chunkEq) || w_isLast) w_stateNext = c_ST_DONE;
            end
            c_ST_DONE: begin
                w_stateNext = start ? c_ST_RUN : c_ST_IDLE;
            end
            default: w_stateNext = c_ST_IDLE;
        endcase
    end

    // Datapath: capture on accepted start, then record the first differing chunk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_signed   <= 1'b0;
            r_diffSeen <= 1'b0;
            r_flags    <= '0;
        end else if (w_accept) begin
            r_idx      <= c_MSB_IDX;
            r_a        <= a;
            r_b        <= b;
            r_signed   <= signed_mode;
            r_diffSeen <= 1'b0;
            r_flags    <= '0;
        end else if (r_state == c_ST_RUN) begin
            if (!r_diffSeen) begin
                if (!w_chunkEq) begin
                    r_flags[c_FLAG_LT] <= w_chunkLt;
                    r_flags[c_FLAG_GT] <= ~w_chunkLt;
                    r_diffSeen         <= 1'b1;
                end else if (w_isLast) begin
                    r_flags[c_FLAG_EQ] <= 1'b1;
                end
            end
            r_a <= r_a << CHUNK;
            r_b <= r_b << CHUNK;
            if (!w_isLast) r_idx <= r_idx - c_IDX_ONE;
        end
    end

    // Outputs: handshake decoded from state, result flags held in registers
    always_comb begin
        busy         = (r_state == c_ST_RUN);
        done         = (r_state == c_ST_DONE);
        less_than    = r_flags[c_FLAG_LT];
        equal        = r_flags[c_FLAG_EQ];
        greater_than = r_flags[c_FLAG_GT];
    end

endmodule : seq_compare_nbit
`default_nettype wire

// File: tb/tb_seq_compare_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_compare_nbit
//  Description : Self-checking bench for seq_compare_nbit. Two instances
//                (early exit and fixed latency) share operands; results and
//                latencies are predicted from integer comparison and nibble
//                scanning of the operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_compare_nbit;

    localparam int c_W = 32;
    localparam int c_C = 4;
    localparam int c_N = c_W / c_C;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           startE, startF;
    logic           signedMode;
    logic [c_W-1:0] aIn, bIn;
    logic           busyE, doneE, ltE, eqE, gtE;
    logic           busyF, doneF, ltF, eqF, gtF;

    int nCmp  = 0;
    int nFail = 0;

    seq_compare_nbit #(.WIDTH(c_W), .CHUNK(c_C), .EARLY_EXIT(1'b1)) dutEarly (
        .clk(clk), .rst_n(rst_n), .start(startE), .signed_mode(signedMode),
        .a(aIn), .b(bIn), .busy(busyE), .done(doneE),
        .less_than(ltE), .equal(eqE), .greater_than(gtE)
    );

    seq_compare_nbit #(.WIDTH(c_W), .CHUNK(c_C), .EARLY_EXIT(1'b0)) dutFixed (
        .clk(clk), .rst_n(rst_n), .start(startF), .signed_mode(signedMode),
        .a(aIn), .b(bIn), .busy(busyF), .done(doneF),
        .less_than(ltF), .equal(eqF), .greater_than(gtF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCmp++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] flagsOf(input bit sel);
        return sel ? {gtF, eqF, ltF} : {gtE, eqE, ltE};
    endfunction

    // Reference: {gt, eq, lt} from integer comparison
    function automatic logic [2:0] refFlags(input logic [31:0] x, input logic [31:0] y, input bit sm);
        bit lt, eq;
        eq = (x == y);
        lt = sm ? ($signed(x) < $signed(y)) : (x < y);
        return {(!lt && !eq), eq, lt};
    endfunction

    // Reference latency: position of the first differing nibble from the top
    function automatic int refLat(input logic [31:0] x, input logic [31:0] y, input bit early);
        logic [31:0] d;
        if (!early) return c_N;
        d = x ^ y;
        for (int i = 0; i < c_N; i++) begin
            if (d[c_W-1-c_C*i -: c_C] != '0) return i + 1;
        end
        return c_N;
    endfunction

    // Drive a request at the current phase, let edge T0 take it, return at T0+1ns
    task automatic launch(input bit sel, input logic [31:0] x, input logic [31:0] y, input bit sm, input string tag);
        aIn = x; bIn = y; signedMode = sm;
        if (sel) startF = 1'b1; else startE = 1'b1;
        @(posedge clk);
        #1;
        startE = 1'b0; startF = 1'b0;
        aIn = $urandom; bIn = $urandom; signedMode = $urandom_range(0, 1);
        check({tag, " busy@T0"}, sel ? busyF : busyE, 1);
        check({tag, " flagsClear@T0"}, flagsOf(sel), 3'b000);
    endtask

    // Count edges until done, then check latency, flags and (optionally) the pulse tail
    task automatic waitResult(input bit sel, input logic [2:0] ef, input int ek, input bit tail, input string tag);
        int k;
        k = 0;
        for (int c = 1; c <= 3 * c_N && k == 0; c++) begin
            @(posedge clk);
            #1;
            if (sel ? doneF : doneE) k = c;
        end
        check({tag, " latency"}, k, ek);
        check({tag, " flags"}, flagsOf(sel), ef);
        check({tag, " busy@done"}, sel ? busyF : busyE, 0);
        if (tail) begin
            @(posedge clk);
            #1;
            check({tag, " donePulse"}, sel ? doneF : doneE, 0);
            check({tag, " flagsHeld"}, flagsOf(sel), ef);
        end
    endtask

    task automatic runOne(input bit sel, input logic [31:0] x, input logic [31:0] y, input bit sm, input string tag);
        launch(sel, x, y, sm, tag);
        waitResult(sel, refFlags(x, y, sm), refLat(x, y, !sel), 1'b1, tag);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          pos;
        rst_n = 1'b0; startE = 1'b0; startF = 1'b0; signedMode = 1'b0;
        aIn = '0; bIn = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset E", {busyE, doneE, gtE, eqE, ltE}, 5'b0);
        check("reset F", {busyF, doneF, gtF, eqF, ltF}, 5'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        runOne(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "eqAllOnes");
        runOne(0, 32'h12311111, 32'h00100000, 0, "gtMsb");
        runOne(0, 32'h10000100, 32'h11000010, 0, "ltSecond");
        runOne(0, 32'hFFFFFFFF, 32'h00000001, 1, "signedLt");
        runOne(0, 32'hFFFFFFFF, 32'h00000001, 0, "unsignedGt");
        runOne(1, 32'h12311111, 32'h00100000, 0, "fixedGt");
        runOne(1, 32'h80000000, 32'h7FFFFFFF, 1, "fixedSignedMin");

        // Back-to-back: new start during the DONE cycle
        launch(0, 32'h10000100, 32'h11000010, 0, "b2bFirst");
        waitResult(0, 3'b001, 2, 1'b0, "b2bFirst");
        launch(0, 32'hFFFFFFFF, 32'h00000001, 1, "b2bSecond");
        waitResult(0, 3'b001, 1, 1'b1, "b2bSecond");

        // Start ignored while busy, then asynchronous abort mid-compare
        launch(1, 32'h11111000, 32'h00001111, 0, "abort");
        aIn = 32'h00000000; bIn = 32'hFFFFFFFF; startF = 1'b1;
        @(posedge clk);
        #1;
        startF = 1'b0;
        check("abort busyT1", busyF, 1);
        check("abort noDoneT1", doneF, 0);
        @(posedge clk);
        #1;
        check("abort noDoneT2", doneF, 0);
        @(posedge clk);
        #1;
        check("abort busyT3", busyF, 1);
        rst_n = 1'b0;
        #1;
        check("abort cleared F", {busyF, doneF, gtF, eqF, ltF}, 5'b0);
        check("abort cleared E", {busyE, doneE, gtE, eqE, ltE}, 5'b0);
        @(posedge clk);
        #1;
        check("abort noDone", {doneF, doneE}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runOne(0, 32'h11111000, 32'h00001111, 0, "afterReset");

        // Randomized cases with a bias toward shared upper nibbles
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0: rb = $urandom;
                1: rb = ra;
                default: begin
                    pos = $urandom_range(0, c_N - 1);
                    rb  = ra ^ (32'($urandom_range(1, 15)) << (c_C * pos));
                end
            endcase
            runOne(i[0], ra, rb, $urandom_range(0, 1), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule : tb_seq_compare_nbit
`default_nettype wire
